led_round_sequencer: RTL and testbench

Upstream stage of the hit-or-miss game FSM. Picks a pseudo-random target LED out of 18, lights it for a fixed round period, and pulses a one-cycle timer-expired strobe when the round times out unhit. Its `leds_out` and `timer_expired_out` feed the game FSM directly. The FSM's reset-sequencer strobe drives `new_round_in` and ends the current round early.

---
 rtl/led_round_sequencer_if.sv | 49 ++++
 rtl/led_round_sequencer.sv | 176 +++++++++++++++++
 tb/tb_led_round_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_round_sequencer_if.sv
// Purpose: control inputs and LED/status outputs of led_round_sequencer, bundled.
// Latency: n/a (wires only).
// Backpressure: none; the control inputs are level/strobe signals and all outputs are registered.
//
// Ports (as seen by the sequencer through the slave modport):
//   start_in          in   start sequencing (honoured only while idle)
//   stop_in           in   abort to idle, highest priority
//   new_round_in      in   end the current round early (target hit)
//   leds_out          out  one-hot target LED or all zero
//   timer_expired_out out  one-cycle pulse when a round times out unhit
//   round_active_out  out  high while a target is shown
//   led_index_out     out  index of the current target, 0..NUM_LEDS-1
//   round_count_out   out  rounds started since start_in, saturating
interface led_round_sequencer_if #(
  parameter int NUM_LEDS = 18
);
  logic                start_in;
  logic                stop_in;
  logic                new_round_in;
  logic [NUM_LEDS-1:0] leds_out;
  logic                timer_expired_out;
  logic                round_active_out;
  logic [4:0]          led_index_out;
  logic [15:0]         round_count_out;

  // Driver side (game FSM / testbench).
  modport master (
    output start_in,
    output stop_in,
    output new_round_in,
    input  leds_out,
    input  timer_expired_out,
    input  round_active_out,
    input  led_index_out,
    input  round_count_out
  );

  // Sequencer side.
  modport slave (
    input  start_in,
    input  stop_in,
    input  new_round_in,
    output leds_out,
    output timer_expired_out,
    output round_active_out,
    output led_index_out,
    output round_count_out
  );
endinterface

// File: rtl/led_round_sequencer.sv
// Purpose: picks a pseudo-random target LED, lights it for ROUND_CYCLES, then GAP_CYCLES dark, repeat.
// Latency: start_in -> LED lit after 2 edges (IDLE->LOAD->SHOW); all outputs registered.
// Backpressure: none; stop_in aborts at once, new_round_in ends a SHOW early, start ignored unless idle.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      led_round_sequencer_if.slave (control strobes in, LED vector and status out)
module led_round_sequencer #(
  parameter int          NUM_LEDS     = 18,
  parameter int          ROUND_CYCLES = 50_000_000,
  parameter int          GAP_CYCLES   = 5_000_000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  led_round_sequencer_if.slave bus
);

  // One shared counter times both SHOW and GAP, so it is sized for the longer phase.
  localparam int MAX_CYC = (ROUND_CYCLES > GAP_CYCLES) ? ROUND_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]    ROUND_LAST = CNT_W'(ROUND_CYCLES - 1);
  localparam logic [CNT_W-1:0]    GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [4:0]          IDX_MAX    = 5'(NUM_LEDS - 1);
  localparam logic [4:0]          IDX_WRAP   = 5'(NUM_LEDS);
  localparam logic [4:0]          IDX_NONE   = 5'd31;
  localparam logic [NUM_LEDS-1:0] LED_ONE    = NUM_LEDS'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHOW,
    ST_GAP
  } state_e;

  state_e              state_q,     state_d;
  logic [15:0]         lfsr_q,      lfsr_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [NUM_LEDS-1:0] leds_q,      leds_d;
  logic                tmr_exp_q,   tmr_exp_d;
  logic                active_q,    active_d;
  logic [4:0]          led_idx_q,   led_idx_d;
  logic [15:0]         round_cnt_q, round_cnt_d;
  logic [4:0]          prev_idx_q,  prev_idx_d;

  // Target index from the low 5 LFSR bits. A single conditional subtract folds
  // 0..31 onto 0..17 (slightly biased toward 0..13, acceptable for a game).
  // A repeat of the previous target is bumped to the next LED so the player
  // always sees the light move.
  logic       lfsr_fb;
  logic [4:0] raw_idx;
  logic [4:0] fold_idx;
  logic [4:0] pick_idx;

  always_comb begin
    lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    raw_idx  = lfsr_q[4:0];
    fold_idx = (raw_idx >= IDX_WRAP) ? (raw_idx - IDX_WRAP) : raw_idx;
    pick_idx = fold_idx;
    if (fold_idx == prev_idx_q) begin
      pick_idx = (fold_idx == IDX_MAX) ? 5'd0 : (fold_idx + 5'd1);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = {lfsr_q[14:0], lfsr_fb};  // free-running in every state
    cnt_d       = cnt_q;
    leds_d      = leds_q;
    tmr_exp_d   = 1'b0;                     // strobe: only ever high for one cycle
    active_d    = active_q;
    led_idx_d   = led_idx_q;
    round_cnt_d = round_cnt_q;
    prev_idx_d  = prev_idx_q;

    if (bus.stop_in) begin
      // Abort beats every other event; index and round count stay visible.
      state_d  = ST_IDLE;
      leds_d   = '0;
      active_d = 1'b0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          leds_d   = '0;
          active_d = 1'b0;
          if (bus.start_in) begin
            state_d     = ST_LOAD;
            round_cnt_d = '0;
          end
        end

        ST_LOAD: begin
          leds_d      = LED_ONE << pick_idx;
          led_idx_d   = pick_idx;
          prev_idx_d  = pick_idx;
          cnt_d       = '0;
          active_d    = 1'b1;
          round_cnt_d = (round_cnt_q == 16'hFFFF) ? round_cnt_q : (round_cnt_q + 16'd1);
          state_d     = ST_SHOW;
        end

        ST_SHOW: begin
          // A hit wins over a timeout landing on the same cycle: no expiry pulse.
          if (bus.new_round_in) begin
            state_d  = ST_GAP;
            leds_d   = '0;
            active_d = 1'b0;
            cnt_d    = '0;
          end else if (cnt_q == ROUND_LAST) begin
            state_d   = ST_GAP;
            leds_d    = '0;
            active_d  = 1'b0;
            cnt_d     = '0;
            tmr_exp_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_GAP: begin
          // new_round_in has no meaning here and is ignored.
          leds_d = '0;
          if (cnt_q == GAP_LAST) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d  = ST_IDLE;
          leds_d   = '0;
          active_d = 1'b0;
          cnt_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= LFSR_SEED;
      cnt_q       <= '0;
      leds_q      <= '0;
      tmr_exp_q   <= 1'b0;
      active_q    <= 1'b0;
      led_idx_q   <= 5'd0;
      round_cnt_q <= 16'd0;
      prev_idx_q  <= IDX_NONE;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      leds_q      <= leds_d;
      tmr_exp_q   <= tmr_exp_d;
      active_q    <= active_d;
      led_idx_q   <= led_idx_d;
      round_cnt_q <= round_cnt_d;
      prev_idx_q  <= prev_idx_d;
    end
  end

  assign bus.leds_out          = leds_q;
  assign bus.timer_expired_out = tmr_exp_q;
  assign bus.round_active_out  = active_q;
  assign bus.led_index_out     = led_idx_q;
  assign bus.round_count_out   = round_cnt_q;

endmodule

// File: tb/tb_led_round_sequencer.sv
// Purpose: self-checking bench for led_round_sequencer (two parameterisations, shared stimulus).
// Latency: outputs compared every cycle, 1 ns after the rising edge, against a round-level model.
// Backpressure: n/a.
module tb_led_round_sequencer;

  localparam int          NL    = 18;
  localparam int          RC0   = 8;
  localparam int          GC0   = 2;
  localparam logic [15:0] SEED0 = 16'h0001;
  localparam int          RC1   = 2;
  localparam int          GC1   = 1;
  localparam logic [15:0] SEED1 = 16'hACE1;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_LOAD = 2'd1;
  localparam logic [1:0] PH_SHOW = 2'd2;
  localparam logic [1:0] PH_GAP  = 2'd3;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  led_round_sequencer_if #(.NUM_LEDS(NL)) bus0 ();
  led_round_sequencer_if #(.NUM_LEDS(NL)) bus1 ();

  led_round_sequencer #(
    .NUM_LEDS(NL), .ROUND_CYCLES(RC0), .GAP_CYCLES(GC0), .LFSR_SEED(SEED0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  led_round_sequencer #(
    .NUM_LEDS(NL), .ROUND_CYCLES(RC1), .GAP_CYCLES(GC1), .LFSR_SEED(SEED1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  // Round-level reference: "remain" counts cycles left in the current lit or dark period.
  typedef struct packed {
    logic [1:0]  phase;
    int          remain;
    logic [15:0] lfsr;
    int          prev;
    logic [17:0] leds;
    logic        expired;
    logic        active;
    int          idx;
    int          rounds;
  } mdl_t;

  mdl_t m0, m1;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic mdl_t mdl_reset(input logic [15:0] seed);
    mdl_t m;
    m         = '0;
    m.phase   = PH_IDLE;
    m.lfsr    = seed;
    m.prev    = 31;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m_in, input bit s, input bit p, input bit n,
                                    input int rc, input int gc);
    mdl_t        m;
    logic [15:0] cur;
    int          pick;
    m         = m_in;
    cur       = m.lfsr;
    m.lfsr    = {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    m.expired = 1'b0;
    if (p) begin
      m.phase  = PH_IDLE;
      m.leds   = '0;
      m.active = 1'b0;
      return m;
    end
    case (m.phase)
      PH_IDLE: if (s) begin
        m.phase  = PH_LOAD;
        m.rounds = 0;
      end
      PH_LOAD: begin
        pick = (int'(cur) % 32) % 18;
        if (pick == m.prev) pick = (pick + 1) % 18;
        m.prev       = pick;
        m.idx        = pick;
        m.leds       = '0;
        m.leds[pick] = 1'b1;
        m.active     = 1'b1;
        m.remain     = rc;
        m.phase      = PH_SHOW;
        if (m.rounds < 65535) m.rounds = m.rounds + 1;
      end
      PH_SHOW: begin
        if (n) begin
          m.phase  = PH_GAP;
          m.leds   = '0;
          m.active = 1'b0;
          m.remain = gc;
        end else begin
          m.remain = m.remain - 1;
          if (m.remain == 0) begin
            m.phase   = PH_GAP;
            m.leds    = '0;
            m.active  = 1'b0;
            m.remain  = gc;
            m.expired = 1'b1;
          end
        end
      end
      default: begin
        m.remain = m.remain - 1;
        if (m.remain == 0) m.phase = PH_LOAD;
      end
    endcase
    return m;
  endfunction

  function automatic logic [63:0] mdl_pack(input mdl_t m);
    return 64'({m.leds, m.expired, m.active, 5'(m.idx), 16'(m.rounds)});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("d0_outputs", 64'({bus0.leds_out, bus0.timer_expired_out, bus0.round_active_out,
                             bus0.led_index_out, bus0.round_count_out}), mdl_pack(m0));
    check("d1_outputs", 64'({bus1.leds_out, bus1.timer_expired_out, bus1.round_active_out,
                             bus1.led_index_out, bus1.round_count_out}), mdl_pack(m1));
    check("d0_onehot", 64'($onehot0(bus0.leds_out)), 64'd1);
    check("d1_lit_only_active", 64'((bus1.leds_out != '0) && !bus1.round_active_out), 64'd0);
  endtask

  task automatic drive(input bit s, input bit p, input bit n);
    bus0.start_in = s; bus0.stop_in = p; bus0.new_round_in = n;
    bus1.start_in = s; bus1.stop_in = p; bus1.new_round_in = n;
  endtask

  // Called away from the edge; inputs settle, one rising edge, then compare.
  task automatic cycle(input bit s, input bit p, input bit n);
    drive(s, p, n);
    @(posedge clk);
    m0 = mdl_step(m0, s, p, n, RC0, GC0);
    m1 = mdl_step(m1, s, p, n, RC1, GC1);
    #1;
    compare_all();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    m0 = mdl_reset(SEED0);
    m1 = mdl_reset(SEED1);
    #1;
    compare_all();
    check("rst_leds", 64'(bus0.leds_out), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  int lit;
  bit seen;

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    #2;
    do_reset();

    // Start sampled on the first edge after reset: LOAD sees lfsr 0x0002.
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("t1_leds", 64'(bus0.leds_out), 64'h4);
    check("t1_idx", 64'(bus0.led_index_out), 64'd2);
    check("t1_rounds", 64'(bus0.round_count_out), 64'd1);

    // Timeout: lit exactly 8 cycles, then a single expiry pulse.
    lit = 1;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (bus0.leds_out != 18'h4) break;
      lit++;
    end
    check("t2_lit_cycles", 64'(lit), 64'd8);
    check("t2_expired", 64'(bus0.timer_expired_out), 64'd1);
    cycle(1'b0, 1'b0, 1'b0);
    check("t2_expired_once", 64'(bus0.timer_expired_out), 64'd0);
    cycle(1'b0, 1'b0, 1'b0);
    check("t2_gap_dark", 64'(bus0.leds_out), 64'd0);
    cycle(1'b0, 1'b0, 1'b0);
    // LOAD saw lfsr 0x1002 -> raw 2 repeats previous 2 -> bumped to 3.
    check("t2_leds", 64'(bus0.leds_out), 64'h8);
    check("t2_idx", 64'(bus0.led_index_out), 64'd3);
    check("t2_rounds", 64'(bus0.round_count_out), 64'd2);

    // Hit on the 3rd SHOW cycle.
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("t3_dark", 64'(bus0.leds_out), 64'd0);
    check("t3_no_expiry", 64'(bus0.timer_expired_out), 64'd0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("t3_load_dark", 64'(bus0.leds_out), 64'd0);
    cycle(1'b0, 1'b0, 1'b0);
    check("t3_next_active", 64'(bus0.round_active_out), 64'd1);
    check("t3_rounds", 64'(bus0.round_count_out), 64'd3);

    // Hit on the same cycle the round would time out.
    repeat (7) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("t4_dark", 64'(bus0.leds_out), 64'd0);
    check("t4_no_expiry", 64'(bus0.timer_expired_out), 64'd0);
    cycle(1'b0, 1'b0, 1'b0);
    check("t4_no_expiry_late", 64'(bus0.timer_expired_out), 64'd0);

    // Randomised traffic.
    for (int k = 0; k < 4000; k++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 11) == 0);
    end

    // Stop mid-SHOW, then restart.
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("t6_restart_clear", 64'(bus0.round_count_out), 64'd0);
    cycle(1'b0, 1'b0, 1'b0);
    check("t6_first_round", 64'(bus0.round_count_out), 64'd1);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check("t6_stop_dark", 64'(bus0.leds_out), 64'd0);
    check("t6_stop_inactive", 64'(bus0.round_active_out), 64'd0);
    check("t6_stop_held", 64'(bus0.round_count_out), 64'd1);
    cycle(1'b1, 1'b0, 1'b0);
    check("t6_start_clear", 64'(bus0.round_count_out), 64'd0);
    cycle(1'b0, 1'b0, 1'b0);
    check("t6_after_load", 64'(bus0.round_count_out), 64'd1);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus0.round_active_out) begin
        seen = 1'b1;
        break;
      end
      cycle(1'b0, 1'b0, 1'b0);
    end
    check("t6_show_reached", 64'(seen), 64'd1);
    cycle(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-SHOW, then the seed sequence must replay.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("t6_reseed_leds", 64'(bus0.leds_out), 64'h4);
    check("t6_reseed_idx", 64'(bus0.led_index_out), 64'd2);
    repeat (20) cycle(1'b0, 1'b0, $urandom_range(0, 5) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
